// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU instruction prefetch slice.
package gpu_pkg;

  localparam int unsigned GPU_WADDR_W = 23;  // 16-bit word address width
  localparam int unsigned GPU_LADDR_W = 22;  // 32-bit longword address width

  localparam logic [GPU_WADDR_W-1:0] GPU_RESET_PC = 23'h7F8004;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_DRAIN
  } fetch_state_t;

endpackage

// File: rtl/gpu_prefetch_fifo.sv
// Circular buffer of 16-bit instruction words with dual-word push,
// single-word pop and synchronous flush.
module gpu_prefetch_fifo
  import gpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_push0,
  input  logic                     i_push1,
  input  logic [15:0]              i_din0,
  input  logic [15:0]              i_din1,
  input  logic                     i_pop,
  output logic [15:0]              o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;

  logic [AW-1:0] w_wr1;
  logic [AW:0]   w_count_nxt;

  // Second word lands one slot after the first when both are pushed.
  always_comb begin
    w_wr1       = i_push0 ? r_wr + 1'b1 : r_wr;
    w_count_nxt = r_count + (AW+1)'(i_push0) + (AW+1)'(i_push1) - (AW+1)'(i_pop);
  end

  // Storage array; contents are only observable while the count covers them.
  always_ff @(posedge i_clk) begin
    if (!i_flush) begin
      if (i_push0) r_mem[r_wr]  <= i_din0;
      if (i_push1) r_mem[w_wr1] <= i_din1;
    end
  end

  // Pointers and occupancy; flush empties the buffer in one cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= r_wr + AW'(i_push0) + AW'(i_push1);
      r_rd    <= r_rd + AW'(i_pop);
      r_count <= w_count_nxt;
    end
  end

  // The controller's space check must make overflow impossible.
  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_flush) begin
      assert (w_count_nxt <= (AW+1)'(DEPTH));
    end
  end

  // Head reads as zero while the buffer is empty.
  always_comb begin
    o_head  = (r_count != '0) ? r_mem[r_rd] : '0;
    o_count = r_count;
  end

endmodule

// File: rtl/gpu_prefetch_ctrl.sv
// GPU instruction prefetch controller: longword fetch FSM with req/ack
// handshake, jump flush/redirect and head/fetch address tracking.
module gpu_prefetch_ctrl
  import gpu_pkg::*;
#(
  parameter int unsigned            QDEPTH   = 4,
  parameter logic [GPU_WADDR_W-1:0] RESET_PC = GPU_RESET_PC
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic                     go,
  output logic                     progreq,
  output logic [GPU_LADDR_W-1:0]   progaddr,
  input  logic                     progack,
  input  logic [31:0]              prog_din,
  input  logic                     jump,
  input  logic [GPU_WADDR_W-1:0]   jump_addr,
  output logic [15:0]              instr,
  output logic                     instr_valid,
  input  logic                     instr_take,
  output logic [$clog2(QDEPTH):0]  qcount,
  output logic [23:0]              program_count
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic [GPU_WADDR_W-1:0] r_fetch_pc;
  logic [GPU_WADDR_W-1:0] r_head_pc;
  logic [GPU_WADDR_W-1:0] w_fetch_pc_nxt;
  logic [GPU_LADDR_W-1:0] r_progaddr;

  logic [CW-1:0] w_count;
  logic [15:0]   w_head;
  logic [CW:0]   w_free;
  logic [1:0]    w_need;
  logic          w_space;
  logic          w_pop;
  logic          w_accept;
  logic          w_push0;
  logic          w_push1;

  gpu_prefetch_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .i_clk   (sys_clk),
    .i_rst   (reset),
    .i_flush (jump),
    .i_push0 (w_push0),
    .i_push1 (w_push1),
    .i_din0  (prog_din[31:16]),
    .i_din1  (prog_din[15:0]),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Space check counts a same-cycle pop as free; a jump suppresses both pop and push.
  always_comb begin
    w_need   = r_fetch_pc[0] ? 2'd1 : 2'd2;
    w_pop    = instr_take && (w_count != '0) && !jump;
    w_free   = (CW+1)'(QDEPTH) - (CW+1)'(w_count) + (CW+1)'(w_pop);
    w_space  = (w_free >= (CW+1)'(w_need));
    w_accept = (r_state == FETCH_REQ) && progack && !jump;
    w_push0  = w_accept && !r_fetch_pc[0];
    w_push1  = w_accept;
  end

  // Fetch-state transitions; an outstanding request always runs to its ack.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FETCH_IDLE:  if (go && w_space && !jump) w_state_nxt = FETCH_REQ;
      FETCH_REQ:   if (progack) w_state_nxt = FETCH_IDLE;
                   else if (jump) w_state_nxt = FETCH_DRAIN;
      FETCH_DRAIN: if (progack) w_state_nxt = FETCH_IDLE;
      default:     w_state_nxt = FETCH_IDLE;
    endcase
  end

  // Next fetch address: jump redirects, an accepted longword advances by the words kept.
  always_comb begin
    w_fetch_pc_nxt = r_fetch_pc;
    if (jump)          w_fetch_pc_nxt = jump_addr;
    else if (w_accept) w_fetch_pc_nxt = r_fetch_pc + GPU_WADDR_W'(w_need);
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (reset) r_state <= FETCH_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Address registers; progaddr is frozen while a request is outstanding.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_head_pc  <= RESET_PC;
      r_progaddr <= RESET_PC[GPU_WADDR_W-1:1];
    end else begin
      r_fetch_pc <= w_fetch_pc_nxt;
      if (jump)       r_head_pc <= jump_addr;
      else if (w_pop) r_head_pc <= r_head_pc + 1'b1;
      if ((r_state == FETCH_IDLE) || (w_state_nxt == FETCH_IDLE))
        r_progaddr <= w_fetch_pc_nxt[GPU_WADDR_W-1:1];
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    progreq       = (r_state != FETCH_IDLE);
    progaddr      = r_progaddr;
    instr         = w_head;
    instr_valid   = (w_count != '0);
    qcount        = w_count;
    program_count = {r_head_pc, 1'b0};
  end

endmodule

// File: tb/tb_gpu_prefetch_ctrl.sv
// Self-checking bench for gpu_prefetch_ctrl: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_gpu_prefetch_ctrl;

  localparam int QD = 4;

  logic        sys_clk;
  logic        reset;
  logic        go;
  logic        progreq;
  logic [21:0] progaddr;
  logic        progack;
  logic [31:0] prog_din;
  logic        jump;
  logic [22:0] jump_addr;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_take;
  logic [2:0]  qcount;
  logic [23:0] program_count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: word queue plus fetch/head addresses and one outstanding request.
  logic [15:0] m_q[$];
  logic [22:0] m_fetch;
  logic [22:0] m_head;
  logic [21:0] m_addr;
  bit          m_pend;
  bit          m_drop;

  gpu_prefetch_ctrl #(
    .QDEPTH   (QD),
    .RESET_PC (23'h7F8004)
  ) dut (
    .sys_clk       (sys_clk),
    .reset         (reset),
    .go            (go),
    .progreq       (progreq),
    .progaddr      (progaddr),
    .progack       (progack),
    .prog_din      (prog_din),
    .jump          (jump),
    .jump_addr     (jump_addr),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_take    (instr_take),
    .qcount        (qcount),
    .program_count (program_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Advance one clock: update the model from the inputs being presented, then sample #1 after the edge.
  task automatic step();
    int  need;
    int  free_w;
    bit  pop;
    need   = m_fetch[0] ? 1 : 2;
    pop    = instr_take && (m_q.size() > 0) && !jump;
    free_w = QD - m_q.size() + (pop ? 1 : 0);
    if (reset) begin
      m_q.delete();
      m_fetch = 23'h7F8004;
      m_head  = 23'h7F8004;
      m_pend  = 1'b0;
      m_drop  = 1'b0;
    end else if (jump) begin
      m_q.delete();
      m_fetch = jump_addr;
      m_head  = jump_addr;
      if (m_pend) begin
        if (progack) begin m_pend = 1'b0; m_drop = 1'b0; end
        else m_drop = 1'b1;
      end
    end else begin
      if (pop) begin
        void'(m_q.pop_front());
        m_head = m_head + 23'd1;
      end
      if (m_pend) begin
        if (progack) begin
          if (!m_drop) begin
            if (!m_fetch[0]) m_q.push_back(prog_din[31:16]);
            m_q.push_back(prog_din[15:0]);
            m_fetch = m_fetch + 23'(need);
          end
          m_pend = 1'b0;
          m_drop = 1'b0;
        end
      end else if (go && (free_w >= need)) begin
        m_pend = 1'b1;
        m_addr = m_fetch[22:1];
      end
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int k;
    k = 0;
    while (progreq !== 1'b1 && k < 20) begin step(); k++; end
    n_cmp++;
    if (progreq !== 1'b1) begin n_err++; $display("FAIL %s_req_timeout: progreq=%b required 1", tag, progreq); end
  endtask

  task automatic ack_after(input int dly, input logic [31:0] din);
    for (int i = 1; i < dly; i++) step();
    progack  = 1'b1;
    prog_din = din;
    step();
    progack  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_cmp++; if (progreq !== 1'b0) begin n_err++; $display("FAIL rst_progreq: got %b want 0", progreq); end
    n_cmp++; if (progaddr !== 22'h3FC002) begin n_err++; $display("FAIL rst_progaddr: got %h want 3fc002", progaddr); end
    n_cmp++; if (qcount !== 3'd0) begin n_err++; $display("FAIL rst_qcount: got %0d want 0", qcount); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    n_cmp++; if (instr !== 16'h0) begin n_err++; $display("FAIL rst_instr: got %h want 0000", instr); end
    n_cmp++; if (program_count !== 24'hFF0008) begin n_err++; $display("FAIL rst_pc: got %h want ff0008", program_count); end
  endtask

  task automatic test_basic_fetch();
    reset = 1'b0;
    go    = 1'b1;
    step();
    n_cmp++; if (progreq !== 1'b1) begin n_err++; $display("FAIL basic_req: got %b want 1", progreq); end
    n_cmp++; if (progaddr !== 22'h3FC002) begin n_err++; $display("FAIL basic_addr: got %h want 3fc002", progaddr); end
    ack_after(2, 32'h1111_2222);
    n_cmp++; if (qcount !== 3'd2) begin n_err++; $display("FAIL basic_qcount: got %0d want 2", qcount); end
    n_cmp++; if (instr !== 16'h1111) begin n_err++; $display("FAIL basic_instr: got %h want 1111", instr); end
    n_cmp++; if (program_count !== 24'hFF0008) begin n_err++; $display("FAIL basic_pc: got %h want ff0008", program_count); end
  endtask

  task automatic test_fill();
    wait_req("fill");
    n_cmp++; if (progaddr !== 22'h3FC003) begin n_err++; $display("FAIL fill_addr: got %h want 3fc003", progaddr); end
    ack_after(2, 32'h3333_4444);
    n_cmp++; if (qcount !== 3'd4) begin n_err++; $display("FAIL fill_full: got %0d want 4", qcount); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (progreq !== 1'b0) begin n_err++; $display("FAIL fill_noreq: got %b want 0", progreq); end
    end
    instr_take = 1'b1; step(); instr_take = 1'b0;
    n_cmp++; if (instr !== 16'h2222) begin n_err++; $display("FAIL fill_take_instr: got %h want 2222", instr); end
    n_cmp++; if (program_count !== 24'hFF000A) begin n_err++; $display("FAIL fill_take_pc: got %h want ff000a", program_count); end
    n_cmp++; if (qcount !== 3'd3) begin n_err++; $display("FAIL fill_take_q: got %0d want 3", qcount); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (progreq !== 1'b0) begin n_err++; $display("FAIL fill_q3_noreq: got %b want 0", progreq); end
    end
    instr_take = 1'b1; step(); instr_take = 1'b0;
    n_cmp++; if (progreq !== 1'b1) begin n_err++; $display("FAIL fill_pop_req: got %b want 1", progreq); end
    n_cmp++; if (progaddr !== 22'h3FC004) begin n_err++; $display("FAIL fill_pop_addr: got %h want 3fc004", progaddr); end
    n_cmp++; if (instr !== 16'h3333) begin n_err++; $display("FAIL fill_pop_instr: got %h want 3333", instr); end
  endtask

  task automatic test_jump_idle();
    ack_after(1, 32'h5555_6666);
    n_cmp++; if (qcount !== 3'd4) begin n_err++; $display("FAIL jidle_full: got %0d want 4", qcount); end
    jump = 1'b1; jump_addr = 23'h000101; step(); jump = 1'b0;
    n_cmp++; if (qcount !== 3'd0) begin n_err++; $display("FAIL jidle_flush: got %0d want 0", qcount); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL jidle_valid: got %b want 0", instr_valid); end
    n_cmp++; if (progreq !== 1'b0) begin n_err++; $display("FAIL jidle_req_n1: got %b want 0", progreq); end
    n_cmp++; if (program_count !== 24'h000202) begin n_err++; $display("FAIL jidle_pc: got %h want 000202", program_count); end
    step();
    n_cmp++; if (progreq !== 1'b1) begin n_err++; $display("FAIL jidle_req_n2: got %b want 1", progreq); end
    n_cmp++; if (progaddr !== 22'h000080) begin n_err++; $display("FAIL jidle_addr: got %h want 000080", progaddr); end
    ack_after(2, 32'hAAAA_BBBB);
    n_cmp++; if (qcount !== 3'd1) begin n_err++; $display("FAIL jidle_odd_q: got %0d want 1", qcount); end
    n_cmp++; if (instr !== 16'hBBBB) begin n_err++; $display("FAIL jidle_odd_instr: got %h want bbbb", instr); end
    n_cmp++; if (program_count !== 24'h000202) begin n_err++; $display("FAIL jidle_odd_pc: got %h want 000202", program_count); end
    wait_req("jidle");
    n_cmp++; if (progaddr !== 22'h000081) begin n_err++; $display("FAIL jidle_next_addr: got %h want 000081", progaddr); end
  endtask

  task automatic test_jump_req();
    jump = 1'b1; jump_addr = 23'h001230; step(); jump = 1'b0;
    n_cmp++; if (qcount !== 3'd0) begin n_err++; $display("FAIL jreq_flush: got %0d want 0", qcount); end
    n_cmp++; if (program_count !== 24'h002460) begin n_err++; $display("FAIL jreq_pc: got %h want 002460", program_count); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (progreq !== 1'b1) begin n_err++; $display("FAIL jreq_hold_req: got %b want 1", progreq); end
      n_cmp++; if (progaddr !== 22'h000081) begin n_err++; $display("FAIL jreq_hold_addr: got %h want 000081", progaddr); end
      if (i < 2) step();
    end
    progack = 1'b1; prog_din = 32'hDEAD_BEEF; step(); progack = 1'b0;
    n_cmp++; if (qcount !== 3'd0) begin n_err++; $display("FAIL jreq_discard: got %0d want 0", qcount); end
    n_cmp++; if (progreq !== 1'b0) begin n_err++; $display("FAIL jreq_drop: got %b want 0", progreq); end
    step();
    n_cmp++; if (progreq !== 1'b1) begin n_err++; $display("FAIL jreq_new_req: got %b want 1", progreq); end
    n_cmp++; if (progaddr !== 22'h000918) begin n_err++; $display("FAIL jreq_new_addr: got %h want 000918", progaddr); end
  endtask

  task automatic test_jump_ack();
    ack_after(1, 32'h1234_5678);
    n_cmp++; if (instr !== 16'h1234) begin n_err++; $display("FAIL jack_pre_instr: got %h want 1234", instr); end
    wait_req("jack");
    n_cmp++; if (progaddr !== 22'h000919) begin n_err++; $display("FAIL jack_pre_addr: got %h want 000919", progaddr); end
    progack = 1'b1; prog_din = 32'hCAFE_F00D; jump = 1'b1; jump_addr = 23'h7FFFFF; instr_take = 1'b1;
    step();
    progack = 1'b0; jump = 1'b0; instr_take = 1'b0;
    n_cmp++; if (qcount !== 3'd0) begin n_err++; $display("FAIL jack_q: got %0d want 0", qcount); end
    n_cmp++; if (program_count !== 24'hFFFFFE) begin n_err++; $display("FAIL jack_pc: got %h want fffffe", program_count); end
    n_cmp++; if (progreq !== 1'b0) begin n_err++; $display("FAIL jack_idle: got %b want 0", progreq); end
    step();
    n_cmp++; if (progaddr !== 22'h3FFFFF) begin n_err++; $display("FAIL jack_addr: got %h want 3fffff", progaddr); end
    ack_after(1, 32'h5555_6666);
    n_cmp++; if (instr !== 16'h6666) begin n_err++; $display("FAIL jack_odd_instr: got %h want 6666", instr); end
    instr_take = 1'b1; step(); instr_take = 1'b0;
    n_cmp++; if (program_count !== 24'h000000) begin n_err++; $display("FAIL wrap_pc: got %h want 000000", program_count); end
    n_cmp++; if (progaddr !== 22'h000000) begin n_err++; $display("FAIL wrap_addr: got %h want 000000", progaddr); end
  endtask

  task automatic test_go_reset();
    go = 1'b0;
    ack_after(2, 32'h0102_0304);
    n_cmp++; if (qcount !== 3'd2) begin n_err++; $display("FAIL go0_q: got %0d want 2", qcount); end
    n_cmp++; if (instr !== 16'h0102) begin n_err++; $display("FAIL go0_instr: got %h want 0102", instr); end
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (progreq !== 1'b0) begin n_err++; $display("FAIL go0_noreq: got %b want 0", progreq); end
    end
    go = 1'b1; step();
    n_cmp++; if (progaddr !== 22'h000001 || progreq !== 1'b1) begin n_err++; $display("FAIL go1_req: got %b/%h want 1/000001", progreq, progaddr); end
    reset = 1'b1; step();
    n_cmp++; if (progreq !== 1'b0) begin n_err++; $display("FAIL rstreq_drop: got %b want 0", progreq); end
    progack = 1'b1; prog_din = 32'h7777_8888; step(); progack = 1'b0;
    n_cmp++; if (qcount !== 3'd0) begin n_err++; $display("FAIL rst_lateack_q: got %0d want 0", qcount); end
    reset = 1'b0; step();
    n_cmp++; if (progaddr !== 22'h3FC002 || progreq !== 1'b1) begin n_err++; $display("FAIL rst_rereq: got %b/%h want 1/3fc002", progreq, progaddr); end
  endtask

  task automatic test_random();
    logic [15:0] exp_instr;
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 499) == 0);
      go         = ($urandom_range(0, 7) != 0);
      instr_take = $urandom_range(0, 1) != 0;
      jump       = ($urandom_range(0, 31) == 0);
      jump_addr  = 23'($urandom);
      progack    = (progreq === 1'b1) && ($urandom_range(0, 2) == 0);
      prog_din   = $urandom;
      step();
      exp_instr = (m_q.size() != 0) ? m_q[0] : 16'h0000;
      n_cmp++; if (progreq !== m_pend) begin n_err++; $display("FAIL rnd_req c=%0d: got %b want %b", c, progreq, m_pend); end
      if (m_pend) begin
        n_cmp++; if (progaddr !== m_addr) begin n_err++; $display("FAIL rnd_addr c=%0d: got %h want %h", c, progaddr, m_addr); end
      end
      n_cmp++; if (qcount !== 3'(m_q.size())) begin n_err++; $display("FAIL rnd_q c=%0d: got %0d want %0d", c, qcount, m_q.size()); end
      n_cmp++; if (instr_valid !== (m_q.size() != 0)) begin n_err++; $display("FAIL rnd_valid c=%0d: got %b", c, instr_valid); end
      n_cmp++; if (instr !== exp_instr) begin n_err++; $display("FAIL rnd_instr c=%0d: got %h want %h", c, instr, exp_instr); end
      n_cmp++; if (program_count !== {m_head, 1'b0}) begin n_err++; $display("FAIL rnd_pc c=%0d: got %h want %h", c, program_count, {m_head, 1'b0}); end
    end
    reset = 1'b0; jump = 1'b0; progack = 1'b0; instr_take = 1'b0;
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; progack = 1'b0; prog_din = '0;
    jump = 1'b0; jump_addr = '0; instr_take = 1'b0;
    m_fetch = 23'h7F8004; m_head = 23'h7F8004; m_addr = 22'h3FC002;
    m_pend = 1'b0; m_drop = 1'b0;
    test_reset();
    test_basic_fetch();
    test_fill();
    test_jump_idle();
    test_jump_req();
    test_jump_ack();
    test_go_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gpu_prefetch_ctrl.md
Name: gpu_prefetch_ctrl

Overview:
Sequences GPU instruction fetch from local program RAM into a small queue of 16-bit instruction words. It tracks the fetch address and the address of the instruction at the queue head, and issues longword read requests with a req/ack handshake. It flushes and redirects on jumps and presents queue occupancy to the PC/decode logic. It sits between the GPU program-RAM port and the instruction decoder, alongside the program-counter datapath.

Parameters:
QDEPTH, 4, queue depth in 16-bit words; power of 2, minimum 4.
RESET_PC, 23'h7F8004, word address loaded at reset (byte address FF0008).

Ports:
sys_clk  in  1  system clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
go  in  1  GPU running; 0 inhibits new requests
progreq  out  1  program read request
progaddr  out  22  longword address of the request (fetch_pc[22:1])
progack  in  1  one-cycle pulse; prog_din valid in the same cycle
prog_din  in  32  fetched longword; big-endian, even word in [31:16]
jump  in  1  redirect strobe
jump_addr  in  23  word address of the jump target
instr  out  16  queue head word
instr_valid  out  1  queue non-empty
instr_take  in  1  decoder consumes head
qcount  out  $clog2(QDEPTH)+1  words in queue
program_count  out  24  byte address of head: {head_pc,1'b0}

Behaviour:
- Reset values:
  - progreq=0, progaddr=RESET_PC[22:1].
  - qcount=0, instr_valid=0, instr=0.
  - program_count={RESET_PC,1'b0}.
  - state=IDLE.
  - fetch_pc=head_pc=RESET_PC.
- Reset mid-request drops the outstanding request without waiting for an ack. A late progack is ignored while reset=1.
- Registers: fetch_pc[22:0] holds the next word to fetch; head_pc[22:0] holds the address of instr.
- Space rule:
  - need = 2 if fetch_pc[0]=0, else 1.
  - The controller may request only when QDEPTH-qcount >= need.
  - The space check must count same-cycle pops as free.
- FSM states:
  - IDLE: if go and the space rule holds and no jump → REQ. progreq and progaddr are registered, so they are asserted the next cycle.
  - REQ: progreq=1 and progaddr held stable until progack.
    - On progack without jump: push prog_din[31:16] (only if fetch_pc[0]=0), then prog_din[15:0]. fetch_pc += need. Go to IDLE.
    - A jump arriving while in REQ without ack → DRAIN.
  - DRAIN: progreq stays 1 with the old progaddr. progreq must never drop before ack. On progack, discard the data and go to IDLE.
- Jump handling:
  - Jump in any state: queue flushed (qcount=0), fetch_pc=head_pc=jump_addr next cycle.
  - Jump coincident with progack in REQ: the ack data is discarded and the state goes to IDLE.
  - Jump coincident with instr_take: the jump wins and the take is ignored.
- Odd jump target: the first fetch of longword jump_addr[22:1] keeps only [15:0]. Subsequent fetches are even-aligned, two words each.
- Pop: instr_take while instr_valid → head advances, head_pc+1.
  - instr_take while the queue is empty is ignored.
  - Push and pop in the same cycle are both honoured.
  - The queue never overflows (guaranteed by the space rule). Overflow is an assertion failure.
- Latency:
  - Data acked at cycle m appears as instr at m+1 if the queue was empty.
  - Jump at cycle n → progreq=1 at n+2, or later if DRAIN.
- Arithmetic: fetch_pc and head_pc are 23-bit and wrap modulo 2^23 silently.
- go=0 does not cancel REQ/DRAIN; the outstanding access completes normally.

Decomposition:
- Shared package gpu_pkg:
  - fetch state enum {IDLE, REQ, DRAIN}.
  - GPU_RESET_PC constant.
  - Word and longword address widths.
- One sub-module: gpu_prefetch_fifo.
  - 16-bit, QDEPTH-deep circular buffer.
  - Interface: push0/push1 dual-word write, pop, flush, count.
  - Controller keeps the FSM, fetch_pc and head_pc.

Test Plan:
1. Reset, go=1, ack 2 cycles after each req with din=32'h1111_2222 → progaddr=22'h3FC002, instr 16'h1111 then 16'h2222, program_count=24'hFF0008 then FF000A.
2. No takes → queue fills to 4 (two fetches), progreq stays 0; one take with qcount=4 → no request until qcount<=2, then next progaddr=22'h3FC004.
3. Jump jump_addr=23'h000101 in IDLE → qcount=0, progaddr=22'h000080; din=32'hAAAA_BBBB pushes only 16'hBBBB; program_count=24'h000202; next fetch progaddr=22'h000081.
4. Jump while REQ pending, ack 3 cycles later with 32'hDEAD_BEEF → progreq held with old address, data discarded, qcount=0, then new request to the target.
5. Jump and progack same cycle, plus instr_take same cycle → ack data dropped, take ignored, head_pc=jump_addr.
6. go=0 during REQ → ack completes the push; no further progreq until go=1; reset asserted in REQ → progreq=0 next cycle, late progack ignored.
